// File: rtl/alu_flag_stage.sv
// Flag/condition stage behind the 64-bit add/subtract unit.
// Derives NZCV per result, commits the architectural flags, and buffers results in a 2-entry FIFO.
module alu_flag_stage #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_of,
    input  logic             in_c,
    input  logic             in_set_flags,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [3:0]       cond,
    output logic             cond_pass,
    output logic [3:0]       flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic [3:0]       out_flags
);

    // Flags are packed {N,Z,C,V}.
    function automatic logic [3:0] calc_nzcv(input logic [WIDTH-1:0] res,
                                             input logic c, input logic v);
        return {res[WIDTH-1], (res == {WIDTH{1'b0}}), c, v};
    endfunction

    function automatic logic eval_cond(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v;
        logic r;
        {n, z, c, v} = f;
        case (cc)
            4'b0000: r = z;
            4'b0001: r = !z;
            4'b0010: r = c;
            4'b0011: r = !c;
            4'b0100: r = n;
            4'b0101: r = !n;
            4'b0110: r = v;
            4'b0111: r = !v;
            4'b1000: r = c & !z;
            4'b1001: r = !c | z;
            4'b1010: r = (n == v);
            4'b1011: r = (n != v);
            4'b1100: r = !z & (n == v);
            4'b1101: r = z | (n != v);
            4'b1110: r = 1'b1;
            4'b1111: r = 1'b1;
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    logic [WIDTH-1:0] mem_result_r [0:1];
    logic [TAG_W-1:0] mem_tag_r    [0:1];
    logic [3:0]       mem_flags_r  [0:1];
    logic             wr_ptr_r;
    logic             rd_ptr_r;
    logic [1:0]       count_r;
    logic [3:0]       flags_r;
    logic             push_s;
    logic             pop_s;
    logic [3:0]       in_nzcv_s;

    assign in_ready   = (count_r != 2'd2);
    assign out_valid  = (count_r != 2'd0);
    assign push_s     = in_valid & in_ready;
    assign pop_s      = out_valid & out_ready;
    assign in_nzcv_s  = calc_nzcv(in_result, in_c, in_of);
    assign out_result = mem_result_r[rd_ptr_r];
    assign out_tag    = mem_tag_r[rd_ptr_r];
    assign out_flags  = mem_flags_r[rd_ptr_r];
    assign flags      = flags_r;
    assign cond_pass  = eval_cond(cond, flags_r);

    // FIFO storage, pointers, occupancy and architectural flag register.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                mem_result_r[i] <= {WIDTH{1'b0}};
                mem_tag_r[i]    <= {TAG_W{1'b0}};
                mem_flags_r[i]  <= 4'b0000;
            end
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
            flags_r  <= 4'b0000;
        end else begin
            if (push_s) begin
                mem_result_r[wr_ptr_r] <= in_result;
                mem_tag_r[wr_ptr_r]    <= in_tag;
                mem_flags_r[wr_ptr_r]  <= in_nzcv_s;
                wr_ptr_r               <= ~wr_ptr_r;
                if (in_set_flags) begin
                    flags_r <= in_nzcv_s;
                end else begin
                    flags_r <= flags_r;
                end
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule
